e203_exu_thread_sched: RTL

//  Thread scheduler driving the one-hot thread_sel consumed by the per-thread CSR banks, regfile and commit logic.

---
 rtl/e203_exu_thread_sched_pkg.sv | 15 +
 rtl/e203_exu_thread_sched_if.sv | 29 ++
 rtl/e203_exu_thread_sched_rr_arb.sv | 28 ++
 rtl/e203_exu_thread_sched.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/e203_exu_thread_sched_pkg.sv
// Shared definitions for the EXU hardware-thread scheduler: default thread
// count, default quantum and the scheduler FSM state encoding.
package e203_exu_thread_sched_pkg;

  localparam int E203_THREADS_NUM    = 2;
  localparam int E203_TSCHED_QUANTUM = 16;

  typedef enum logic [1:0] {
    E203_TSCHED_RUN    = 2'd0,
    E203_TSCHED_DRAIN  = 2'd1,
    E203_TSCHED_SWITCH = 2'd2,
    E203_TSCHED_SLEEP  = 2'd3
  } tsched_state_e;

endpackage

// File: rtl/e203_exu_thread_sched_if.sv
// Scheduler <-> core signal bundle. The master side is the core (commit,
// pipeline status, per-thread enables/interrupts); the slave side is the
// scheduler, which drives thread selection and the halt/drain request.
interface e203_exu_thread_sched_if
  import e203_exu_thread_sched_pkg::*;
#(
  parameter int THREADS_NUM = E203_THREADS_NUM
);
  logic [THREADS_NUM-1:0] thread_en;
  logic [THREADS_NUM-1:0] thread_irq;
  logic                   nonflush_cmt_ena;
  logic                   cmt_wfi_ena;
  logic                   pipe_idle;
  logic                   dbg_mode;
  logic [THREADS_NUM-1:0] thread_sel;
  logic                   halt_req;
  logic                   sched_switch;
  logic                   all_asleep;

  modport master (
    output thread_en, thread_irq, nonflush_cmt_ena, cmt_wfi_ena, pipe_idle, dbg_mode,
    input  thread_sel, halt_req, sched_switch, all_asleep
  );

  modport slave (
    input  thread_en, thread_irq, nonflush_cmt_ena, cmt_wfi_ena, pipe_idle, dbg_mode,
    output thread_sel, halt_req, sched_switch, all_asleep
  );
endinterface

// File: rtl/e203_exu_thread_sched_rr_arb.sv
// Combinational round-robin picker. Searches req starting one position after
// the one-hot cur and wraps around, so cur itself is the last candidate.
module e203_thread_rr_arb #(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] cur,
  output logic [N-1:0] grant,
  output logic         found
);

  // First requester at distance k = 1..N from the current thread wins
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          if (!found && cur[i] && (j == ((i + k) % N)) && req[j]) begin
            grant[j] = 1'b1;
            found    = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/e203_exu_thread_sched.sv
// EXU hardware-thread scheduler. Rotates among runnable threads on quantum
// expiry, WFI or thread disable, draining the pipeline before each switch,
// and tracks per-thread WFI sleep state woken by that thread's interrupt.
// Optional feature macro: E203_THREAD_IRQ_PREEMPT_EN (an interrupt pending on
// another enabled thread preempts the current one and is picked first).
module e203_exu_thread_sched
  import e203_exu_thread_sched_pkg::*;
#(
  parameter int THREADS_NUM = E203_THREADS_NUM,
  parameter int QUANTUM     = E203_TSCHED_QUANTUM
) (
  input  logic                    clk,
  input  logic                    rst_n,
  e203_exu_thread_sched_if.slave  sif
);

  localparam int              QW   = $clog2(QUANTUM);
  localparam logic [QW-1:0]   QMAX = QW'(QUANTUM - 1);

  tsched_state_e          state_q, state_d;
  logic [QW-1:0]          qcnt_q, qcnt_d;
  logic [THREADS_NUM-1:0] asleep_q, asleep_d;
  logic [THREADS_NUM-1:0] thread_sel_q, thread_sel_d;
  logic                   halt_req_q, halt_req_d;
  logic                   sched_switch_q, sched_switch_d;
  logic                   all_asleep_q, all_asleep_d;

  logic [THREADS_NUM-1:0] en_eff;
  logic [THREADS_NUM-1:0] runnable;
  logic                   cur_en;
  logic                   cur_runnable;
  logic [THREADS_NUM-1:0] rr_grant;
  logic                   rr_found;
  logic [THREADS_NUM-1:0] pick_grant;
  logic                   pick_found;
  logic                   preempt;

  // Thread 0 can never be disabled, so there is always a fallback thread
  assign en_eff       = sif.thread_en | {{(THREADS_NUM-1){1'b0}}, 1'b1};
  assign runnable     = en_eff & ~asleep_q;
  assign cur_en       = |(en_eff & thread_sel_q);
  assign cur_runnable = |(runnable & thread_sel_q);

  e203_thread_rr_arb #(.N(THREADS_NUM)) u_rr_arb (
    .req   (runnable),
    .cur   (thread_sel_q),
    .grant (rr_grant),
    .found (rr_found)
  );

`ifdef E203_THREAD_IRQ_PREEMPT_EN
  logic [THREADS_NUM-1:0] irq_grant;
  logic                   irq_found;
  logic [THREADS_NUM-1:0] irq_run;

  assign preempt = |(sif.thread_irq & en_eff & ~thread_sel_q);
  assign irq_run = sif.thread_irq & runnable;

  // Lowest-index runnable thread with a pending interrupt takes priority
  always_comb begin
    irq_grant = '0;
    irq_found = 1'b0;
    for (int i = THREADS_NUM - 1; i >= 0; i--) begin
      if (irq_run[i]) begin
        irq_grant    = '0;
        irq_grant[i] = 1'b1;
        irq_found    = 1'b1;
      end
    end
  end

  assign pick_grant = irq_found ? irq_grant : rr_grant;
  assign pick_found = irq_found | rr_found;
`else
  assign preempt    = 1'b0;
  assign pick_grant = rr_grant;
  assign pick_found = rr_found;
`endif

  // Sleep tracking: WFI on the current thread sets, its interrupt clears (wins)
  always_comb begin
    asleep_d = asleep_q;
    for (int i = 0; i < THREADS_NUM; i++) begin
      if (sif.thread_irq[i]) begin
        asleep_d[i] = 1'b0;
      end else if (sif.cmt_wfi_ena && thread_sel_q[i]) begin
        asleep_d[i] = 1'b1;
      end
    end
  end

  // Scheduler FSM next state, quantum counter and registered output values
  always_comb begin
    state_d        = state_q;
    qcnt_d         = qcnt_q;
    thread_sel_d   = thread_sel_q;
    sched_switch_d = 1'b0;
    unique case (state_q)
      E203_TSCHED_RUN: begin
        if (!sif.dbg_mode) begin
          if (sif.nonflush_cmt_ena && (qcnt_q != QMAX)) begin
            qcnt_d = qcnt_q + 1'b1;
          end
          if ((sif.nonflush_cmt_ena && (qcnt_q == QMAX)) || sif.cmt_wfi_ena ||
              !cur_en || preempt) begin
            state_d = E203_TSCHED_DRAIN;
          end
        end
      end
      E203_TSCHED_DRAIN: begin
        if (sif.pipe_idle) begin
          state_d = E203_TSCHED_SWITCH;
        end
      end
      E203_TSCHED_SWITCH: begin
        qcnt_d = '0;
        if (pick_found && (pick_grant != thread_sel_q)) begin
          thread_sel_d   = pick_grant;
          sched_switch_d = 1'b1;
          state_d        = E203_TSCHED_RUN;
        end else if (cur_runnable) begin
          state_d = E203_TSCHED_RUN;
        end else begin
          state_d = E203_TSCHED_SLEEP;
        end
      end
      E203_TSCHED_SLEEP: begin
        if (|runnable) begin
          state_d = E203_TSCHED_SWITCH;
        end
      end
      default: state_d = E203_TSCHED_RUN;
    endcase
    halt_req_d   = (state_d != E203_TSCHED_RUN);
    all_asleep_d = (state_d == E203_TSCHED_SLEEP);
  end

  // State, counter, sleep bits and output flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= E203_TSCHED_RUN;
      qcnt_q         <= '0;
      asleep_q       <= '0;
      thread_sel_q   <= {{(THREADS_NUM-1){1'b0}}, 1'b1};
      halt_req_q     <= 1'b0;
      sched_switch_q <= 1'b0;
      all_asleep_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      qcnt_q         <= qcnt_d;
      asleep_q       <= asleep_d;
      thread_sel_q   <= thread_sel_d;
      halt_req_q     <= halt_req_d;
      sched_switch_q <= sched_switch_d;
      all_asleep_q   <= all_asleep_d;
    end
  end

  assign sif.thread_sel   = thread_sel_q;
  assign sif.halt_req     = halt_req_q;
  assign sif.sched_switch = sched_switch_q;
  assign sif.all_asleep   = all_asleep_q;

endmodule
